// File: rtl/pong_game_engine.sv
// Frame-rate game-state engine for the two-player pong display path.
// Owns paddle positions, ball position/direction, scoring and match flow,
// advancing once per frame_tick in the clk_out (pixel clock) domain.
// Optional build macro: AI_PADDLE2_EN -- when defined, the right paddle
// ignores p2_up/p2_down and chases ball_y on its own.
module pong_game_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PADDLE_H     = 75,
  parameter int PADDLE_W     = 5,
  parameter int P1_X         = 30,
  parameter int P2_X         = 600,
  parameter int BALL_R       = 8,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_STEP    = 2,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic       point_pulse,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  typedef logic signed [10:0] coord_t;

  localparam int CNT_W = (SERVE_FRAMES < 1) ? 1 : $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0] X_CENTRE     = 10'(H_RES / 2);
  localparam logic [9:0] Y_CENTRE     = 10'(V_RES / 2);
  localparam logic [9:0] PADDLE_START = 10'((V_RES - PADDLE_H) / 2);
  localparam coord_t     PADDLE_MAX   = coord_t'(V_RES - PADDLE_H);
  localparam coord_t     RAD          = coord_t'(BALL_R);
  localparam coord_t     Y_BOTTOM     = coord_t'(V_RES - 1 - BALL_R);
  localparam coord_t     X_RIGHT      = coord_t'(H_RES - 1 - BALL_R);
  localparam coord_t     P1_FACE      = coord_t'(P1_X + PADDLE_W);
  localparam coord_t     P2_FACE      = coord_t'(P2_X);
  localparam coord_t     WIN_SPAN     = coord_t'(PADDLE_H - 1 + BALL_R);

  state_t             state_q, state_d;
  logic [9:0]         ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [9:0]         p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  logic [3:0]         p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic               point_pulse_q, point_pulse_d;
  logic [1:0]         winner_q, winner_d;
  logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;

  coord_t bx, by, nx, ny, p1_top, p2_top;
  logic   hit_p1, hit_p2, score_p1, score_p2;
  logic   p2_up_eff, p2_down_eff;

  // One paddle step from a button pair, clamped to the visible column.
  function automatic logic [9:0] paddle_move(input logic [9:0] y, input logic up, input logic down);
    coord_t t;
    t = coord_t'({1'b0, y});
    if (up && !down) t = t - coord_t'(PADDLE_STEP);
    else if (down && !up) t = t + coord_t'(PADDLE_STEP);
    if (t < coord_t'(0)) t = coord_t'(0);
    else if (t > PADDLE_MAX) t = PADDLE_MAX;
    return t[9:0];
  endfunction

  // Next-state logic: paddle motion, ball flight, collisions, scoring and match flow.
  always_comb begin
    state_d       = state_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    p1_y_d        = p1_y_q;
    p2_y_d        = p2_y_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    point_pulse_d = 1'b0;
    winner_d      = winner_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    serve_cnt_d   = serve_cnt_q;
    score_p1      = 1'b0;
    score_p2      = 1'b0;

    bx     = coord_t'({1'b0, ball_x_q});
    by     = coord_t'({1'b0, ball_y_q});
    p1_top = coord_t'({1'b0, p1_y_q});
    p2_top = coord_t'({1'b0, p2_y_q});
    nx     = dir_x_q ? bx + coord_t'(BALL_STEP) : bx - coord_t'(BALL_STEP);
    ny     = dir_y_q ? by + coord_t'(BALL_STEP) : by - coord_t'(BALL_STEP);

`ifdef AI_PADDLE2_EN
    p2_up_eff   = by < p2_top + coord_t'(PADDLE_H / 2 - PADDLE_STEP);
    p2_down_eff = by > p2_top + coord_t'(PADDLE_H / 2 + PADDLE_STEP);
`else
    p2_up_eff   = p2_up;
    p2_down_eff = p2_down;
`endif

    hit_p1 = !dir_x_q && (bx - RAD > P1_FACE) && (nx - RAD <= P1_FACE) &&
             (by >= p1_top - RAD) && (by <= p1_top + WIN_SPAN);
    hit_p2 = dir_x_q && (bx + RAD < P2_FACE) && (nx + RAD >= P2_FACE) &&
             (by >= p2_top - RAD) && (by <= p2_top + WIN_SPAN);

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d     = S_SERVE;
          p1_score_d  = '0;
          p2_score_d  = '0;
          winner_d    = 2'd0;
          ball_x_d    = X_CENTRE;
          ball_y_d    = Y_CENTRE;
          serve_cnt_d = CNT_W'(SERVE_FRAMES);
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          p1_y_d = paddle_move(p1_y_q, p1_up, p1_down);
          p2_y_d = paddle_move(p2_y_q, p2_up_eff, p2_down_eff);
          if (serve_cnt_q == '0) state_d = S_PLAY;
          else serve_cnt_d = serve_cnt_q - CNT_W'(1);
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          p1_y_d = paddle_move(p1_y_q, p1_up, p1_down);
          p2_y_d = paddle_move(p2_y_q, p2_up_eff, p2_down_eff);
          if (ny < RAD) begin
            ball_y_d = RAD[9:0];
            dir_y_d  = 1'b1;
          end else if (ny > Y_BOTTOM) begin
            ball_y_d = Y_BOTTOM[9:0];
            dir_y_d  = 1'b0;
          end else begin
            ball_y_d = ny[9:0];
          end
          if (hit_p1) begin
            ball_x_d = 10'(P1_X + PADDLE_W + 1 + BALL_R);
            dir_x_d  = 1'b1;
          end else if (hit_p2) begin
            ball_x_d = 10'(P2_X - 1 - BALL_R);
            dir_x_d  = 1'b0;
          end else if (nx <= RAD) begin
            score_p2 = 1'b1;
          end else if (nx >= X_RIGHT) begin
            score_p1 = 1'b1;
          end else begin
            ball_x_d = nx[9:0];
          end
          if (score_p1 || score_p2) begin
            point_pulse_d = 1'b1;
            ball_x_d      = X_CENTRE;
            ball_y_d      = Y_CENTRE;
            dir_y_d       = dir_y_q;
            if (score_p1) begin
              p1_score_d = p1_score_q + 4'd1;
              dir_x_d    = 1'b1;
            end else begin
              p2_score_d = p2_score_q + 4'd1;
              dir_x_d    = 1'b0;
            end
            if (p1_score_d == 4'(WIN_SCORE) || p2_score_d == 4'(WIN_SCORE)) begin
              state_d  = S_OVER;
              winner_d = score_p1 ? 2'd1 : 2'd2;
            end else begin
              state_d     = S_SERVE;
              serve_cnt_d = CNT_W'(SERVE_FRAMES);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset takes effect immediately, even mid-frame.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ball_x_q      <= X_CENTRE;
      ball_y_q      <= Y_CENTRE;
      p1_y_q        <= PADDLE_START;
      p2_y_q        <= PADDLE_START;
      p1_score_q    <= '0;
      p2_score_q    <= '0;
      point_pulse_q <= 1'b0;
      winner_q      <= 2'd0;
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      serve_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      p1_y_q        <= p1_y_d;
      p2_y_q        <= p2_y_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      point_pulse_q <= point_pulse_d;
      winner_q      <= winner_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      serve_cnt_q   <= serve_cnt_d;
    end
  end

  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign p1_y        = p1_y_q;
  assign p2_y        = p2_y_q;
  assign p1_score    = p1_score_q;
  assign p2_score    = p2_score_q;
  assign state       = state_q;
  assign point_pulse = point_pulse_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// Testbench for pong_game_engine: an integer game model tracks the expected
// outputs every cycle, and directed scenarios pin key moments with literals.
module tb_pong_game_engine;

  logic       clk_out = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [9:0] ball_x, ball_y, p1_y, p2_y;
  logic [3:0] p1_score, p2_score;
  logic [1:0] state, winner;
  logic       point_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int bx, by, p1, p2, s1, s2, st, pp, win, dx, dy, cnt;
  } model_t;

  model_t m;

  pong_game_engine dut (
    .clk_out(clk_out), .reset(reset), .frame_tick(frame_tick), .start(start),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
    .p1_score(p1_score), .p2_score(p2_score), .state(state),
    .point_pulse(point_pulse), .winner(winner)
  );

  // Pixel clock.
  always #5 clk_out = ~clk_out;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic a, input logic b, input logic c, input logic d);
    start = st; p1_up = a; p1_down = b; p2_up = c; p2_down = d;
  endtask

  function automatic model_t model_reset();
    model_t r;
    r.bx = 320; r.by = 240; r.p1 = 202; r.p2 = 202; r.s1 = 0; r.s2 = 0;
    r.st = 0; r.pp = 0; r.win = 0; r.dx = 1; r.dy = 1; r.cnt = 0;
    return r;
  endfunction

  function automatic int move_paddle(int y, bit up, bit dn);
    int r = y;
    if (up && !dn) r = y - 4;
    else if (dn && !up) r = y + 4;
    if (r < 0) r = 0;
    if (r > 405) r = 405;
    return r;
  endfunction

  function automatic model_t model_step(model_t cur, bit tick, bit st, bit a, bit b, bit c, bit d);
    model_t n = cur;
    int nx, ny, scorer;
    bit h1, h2;
    n.pp = 0;
    if (cur.st == 0 || cur.st == 3) begin
      if (st) begin
        n.st = 1; n.s1 = 0; n.s2 = 0; n.win = 0; n.cnt = 60; n.bx = 320; n.by = 240;
      end
      return n;
    end
    if (!tick) return n;
    n.p1 = move_paddle(cur.p1, a, b);
`ifdef AI_PADDLE2_EN
    n.p2 = move_paddle(cur.p2, cur.by < cur.p2 + 33, cur.by > cur.p2 + 41);
`else
    n.p2 = move_paddle(cur.p2, c, d);
`endif
    if (cur.st == 1) begin
      if (cur.cnt == 0) n.st = 2;
      else n.cnt = cur.cnt - 1;
      return n;
    end
    nx = cur.bx + 2 * cur.dx;
    ny = cur.by + 2 * cur.dy;
    if (ny < 8) begin n.by = 8; n.dy = 1; end
    else if (ny > 471) begin n.by = 471; n.dy = -1; end
    else n.by = ny;
    h1 = cur.dx < 0 && cur.bx - 8 > 35 && nx - 8 <= 35 && cur.by >= cur.p1 - 8 && cur.by <= cur.p1 + 82;
    h2 = cur.dx > 0 && cur.bx + 8 < 600 && nx + 8 >= 600 && cur.by >= cur.p2 - 8 && cur.by <= cur.p2 + 82;
    scorer = 0;
    if (h1) begin n.bx = 44; n.dx = 1; end
    else if (h2) begin n.bx = 591; n.dx = -1; end
    else if (nx <= 8) scorer = 2;
    else if (nx >= 631) scorer = 1;
    else n.bx = nx;
    if (scorer != 0) begin
      n.pp = 1; n.bx = 320; n.by = 240; n.dy = cur.dy;
      if (scorer == 1) begin n.s1 = cur.s1 + 1; n.dx = 1; end
      else begin n.s2 = cur.s2 + 1; n.dx = -1; end
      if (n.s1 == 7 || n.s2 == 7) begin n.st = 3; n.win = scorer; end
      else begin n.st = 1; n.cnt = 60; end
    end
    return n;
  endfunction

  // Reference game model, advanced on the same edges as the design.
  always @(posedge clk_out or posedge reset) begin
    if (reset) m <= model_reset();
    else m <= model_step(m, frame_tick, start, p1_up, p1_down, p2_up, p2_down);
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk_out) begin
    if (reset === 1'b0) begin
      checkOutput("m_ball_x", 32'(ball_x), 32'(m.bx));
      checkOutput("m_ball_y", 32'(ball_y), 32'(m.by));
      checkOutput("m_p1_y", 32'(p1_y), 32'(m.p1));
      checkOutput("m_p2_y", 32'(p2_y), 32'(m.p2));
      checkOutput("m_p1_score", 32'(p1_score), 32'(m.s1));
      checkOutput("m_p2_score", 32'(p2_score), 32'(m.s2));
      checkOutput("m_state", 32'(state), 32'(m.st));
      checkOutput("m_point_pulse", 32'(point_pulse), 32'(m.pp));
      checkOutput("m_winner", 32'(winner), 32'(m.win));
    end
  end

  // Buttons that steer a paddle centre toward the ball, or park P2 mid-screen.
  task automatic set_tracking(input int mode);
    int c1, c2;
    c1 = int'(p1_y) + 37;
    c2 = int'(p2_y) + 37;
    p1_up   = int'(ball_y) + 2 < c1;
    p1_down = int'(ball_y) > c1 + 2;
    if (mode == 1) begin
      p2_up   = int'(ball_y) + 2 < c2;
      p2_down = int'(ball_y) > c2 + 2;
    end else begin
      p2_up   = int'(p2_y) > 205;
      p2_down = int'(p2_y) < 199;
    end
  endtask

  // One frame: tick high for one cycle, then one quiet cycle.
  task automatic tick(input int mode);
    @(negedge clk_out);
    if (mode != 0) set_tracking(mode);
    frame_tick = 1'b1;
    @(negedge clk_out);
    frame_tick = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_ball_x"}, 32'(ball_x), 32'd320);
    checkOutput({tag, "_ball_y"}, 32'(ball_y), 32'd240);
    checkOutput({tag, "_p1_y"}, 32'(p1_y), 32'd202);
    checkOutput({tag, "_p2_y"}, 32'(p2_y), 32'd202);
    checkOutput({tag, "_scores"}, 32'({p1_score, p2_score}), 32'd0);
    checkOutput({tag, "_state"}, 32'(state), 32'd0);
    checkOutput({tag, "_winner"}, 32'(winner), 32'd0);
  endtask

  // Directed scenario sequence.
  initial begin
    bit seen;
    applyStimulus(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk_out);
    reset = 1'b0;
    @(negedge clk_out);
    check_reset_values("rst");

    repeat (3) tick(0);
    checkOutput("idle_state", 32'(state), 32'd0);

    @(negedge clk_out); start = 1'b1;
    @(negedge clk_out); start = 1'b0;
    checkOutput("start_state", 32'(state), 32'd1);

    applyStimulus(0, 1, 0, 1, 0);
    for (int i = 1; i <= 60; i++) begin
      tick(0);
      if (i == 50) checkOutput("p1_y_50", 32'(p1_y), 32'd2);
      if (i == 51) checkOutput("p1_y_51", 32'(p1_y), 32'd0);
    end
    checkOutput("p1_y_60", 32'(p1_y), 32'd0);
    checkOutput("p2_y_60", 32'(p2_y), 32'd0);
    checkOutput("serve_60_state", 32'(state), 32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    tick(0);
    checkOutput("play_state", 32'(state), 32'd2);
    checkOutput("play_ball_x0", 32'(ball_x), 32'd320);
    tick(0);
    checkOutput("first_move_x", 32'(ball_x), 32'd322);
    checkOutput("first_move_y", 32'(ball_y), 32'd242);

    applyStimulus(0, 0, 1, 0, 0);
    repeat (5) tick(0);
    checkOutput("p1_down_5", 32'(p1_y), 32'd20);
    applyStimulus(0, 1, 1, 0, 0);
    tick(0);
    checkOutput("p1_both_hold", 32'(p1_y), 32'd20);
    applyStimulus(0, 0, 0, 0, 0);

    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick(0);
      seen = point_pulse;
    end
    checkOutput("p2_miss_seen", 32'(seen), 32'd1);
    checkOutput("miss_p1_score", 32'(p1_score), 32'd1);
    checkOutput("miss_p2_score", 32'(p2_score), 32'd0);
    checkOutput("miss_state", 32'(state), 32'd1);
    checkOutput("miss_ball", 32'({ball_x, ball_y}), 32'({10'd320, 10'd240}));
    @(negedge clk_out);
    checkOutput("pulse_one_cycle", 32'(point_pulse), 32'd0);

    seen = 0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      tick(1);
      seen = (ball_x == 10'd45);
    end
    checkOutput("p1_approach_seen", 32'(seen), 32'd1);
    tick(1);
    checkOutput("p1_hit_x", 32'(ball_x), 32'd44);
    checkOutput("p1_hit_score", 32'(p1_score), 32'd1);
    tick(1);
    checkOutput("p1_rebound_x", 32'(ball_x), 32'd46);

    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick(1);
      seen = (ball_y == 10'd9);
    end
    checkOutput("top_approach_seen", 32'(seen), 32'd1);
    tick(1);
    checkOutput("top_wall_y", 32'(ball_y), 32'd8);
    tick(1);
    checkOutput("top_rebound_y", 32'(ball_y), 32'd10);

    @(negedge clk_out);
    #2 reset = 1'b1;
    #1 check_reset_values("async_rst");
    @(negedge clk_out);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk_out);
    check_reset_values("rst_release");

    @(negedge clk_out); start = 1'b1;
    @(negedge clk_out); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 2500 && !seen; i++) begin
      tick(2);
      seen = (state == 2'd3);
    end
    checkOutput("over_seen", 32'(seen), 32'd1);
    checkOutput("over_winner", 32'(winner), 32'd1);
    checkOutput("over_p1_score", 32'(p1_score), 32'd7);
    checkOutput("over_p2_score", 32'(p2_score), 32'd0);

    applyStimulus(0, 0, 1, 0, 1);
    repeat (5) tick(0);
    checkOutput("frozen_state", 32'(state), 32'd3);
    checkOutput("frozen_ball", 32'({ball_x, ball_y}), 32'({10'd320, 10'd240}));
    checkOutput("frozen_winner", 32'(winner), 32'd1);
    applyStimulus(0, 0, 0, 0, 0);

    @(negedge clk_out); start = 1'b1;
    @(negedge clk_out); start = 1'b0;
    checkOutput("restart_state", 32'(state), 32'd1);
    checkOutput("restart_scores", 32'({p1_score, p2_score}), 32'd0);
    checkOutput("restart_winner", 32'(winner), 32'd0);
    repeat (3) tick(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so a stuck run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
